// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer for EX: one-cycle registered multiply, 32-step restoring divide.
// Optional MDU_DIV_EARLY_OUT_EN: divides with |b| > |a| commit after a single busy cycle.
module hilo_mdu_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b, div_q, div_r;
  logic        mul_signed, neg_q, neg_r, early;
  logic [4:0]  count;

  logic        accept, take_div, take_divu, take_mult, take_multu, take_hi, take_lo;
  logic        start_mul, start_div, early_ok, mul_commit, div_commit;
  logic [31:0] mag_a, mag_b, r_step, q_step, r_fix, q_fix;
  logic [32:0] shifted;
  logic        fits;
  logic [63:0] ext_a, ext_b, product;

  // Decode with fixed priority div > divu > mult > multu > mthi > mtlo.
  assign accept     = req_valid & ~busy & ~flush;
  assign take_div   = accept & is_div;
  assign take_divu  = accept & ~is_div & is_divu;
  assign take_mult  = accept & ~is_div & ~is_divu & is_mult;
  assign take_multu = accept & ~is_div & ~is_divu & ~is_mult & is_multu;
  assign take_hi    = accept & ~is_div & ~is_divu & ~is_mult & ~is_multu & hi_wen;
  assign take_lo    = accept & ~is_div & ~is_divu & ~is_mult & ~is_multu & ~hi_wen & lo_wen;
  assign start_mul  = take_mult | take_multu;
  assign start_div  = take_div | take_divu;

  assign mag_a = (take_div & src_a[31]) ? -src_a : src_a;
  assign mag_b = (take_div & src_b[31]) ? -src_b : src_b;

`ifdef MDU_DIV_EARLY_OUT_EN
  assign early_ok = start_div & (mag_b > mag_a) & (mag_b != 32'd0);
`else
  assign early_ok = 1'b0;
`endif

  // Extending by the latched signedness lets one 64-bit multiply serve both ops.
  assign ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
  assign ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
  assign product = ext_a * ext_b;

  // One restoring step; the final step's result feeds the commit directly.
  assign shifted = {div_r, div_q[31]};
  assign fits    = shifted >= {1'b0, op_b};
  assign r_step  = fits ? 32'(shifted - {1'b0, op_b}) : shifted[31:0];
  assign q_step  = {div_q[30:0], fits};
  assign q_fix   = neg_q ? -q_step : q_step;
  assign r_fix   = neg_r ? -r_step : r_step;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    case (state)
      IDLE: begin
        if (start_mul)      state_nxt = MUL;
        else if (start_div) state_nxt = DIV;
      end
      MUL: begin
        state_nxt  = IDLE;
        mul_commit = ~flush;
      end
      DIV: begin
        if (flush) state_nxt = IDLE;
        else if (early || count == LAST_ITER) begin
          state_nxt  = IDLE;
          div_commit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches, divide iteration and HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0; lo <= '0; done <= 1'b0;
      op_a <= '0; op_b <= '0; div_q <= '0; div_r <= '0;
      mul_signed <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; early <= 1'b0;
      count <= '0;
    end else begin
      done <= mul_commit | div_commit;
      if (take_hi) hi <= src_a;
      if (take_lo) lo <= src_a;
      if (start_mul) begin
        op_a       <= src_a;
        op_b       <= src_b;
        mul_signed <= take_mult;
        count      <= '0;
      end
      if (start_div) begin
        op_a  <= src_a;
        op_b  <= mag_b;
        div_q <= mag_a;
        div_r <= '0;
        neg_q <= take_div & (src_a[31] ^ src_b[31]);
        neg_r <= take_div & src_a[31];
        early <= early_ok;
        count <= '0;
      end else if (state == DIV && !flush) begin
        div_q <= q_step;
        div_r <= r_step;
        if (count != LAST_ITER) count <= count + 5'd1;
      end
      if (busy && flush) count <= '0;
      if (mul_commit) {hi, lo} <= product;
      if (div_commit) begin
        if (early) begin
          hi <= op_a;
          lo <= '0;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: directed corner cases plus random ops against an arithmetic model.
// Honours MDU_DIV_EARLY_OUT_EN for the expected divide latency.
module tb_hilo_mdu_ctrl;

  typedef enum int {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} op_e;

  logic        clk = 1'b0;
  logic        reset, req_valid, is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen, flush;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, done;
  logic [31:0] exp_hi, exp_lo;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hilo_mdu_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = 0; is_mult = 0; is_multu = 0; is_div = 0; is_divu = 0;
    hi_wen = 0; lo_wen = 0; flush = 0; src_a = '0; src_b = '0;
  endtask

  task automatic drive_op(input op_e op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1;
    is_mult   = (op == OP_MULT);
    is_multu  = (op == OP_MULTU);
    is_div    = (op == OP_DIV);
    is_divu   = (op == OP_DIVU);
    hi_wen    = (op == OP_MTHI);
    lo_wen    = (op == OP_MTLO);
    src_a     = a;
    src_b     = b;
  endtask

  // Architectural result of each op, computed with plain 64-bit arithmetic.
  task automatic model(input op_e op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    longint      sp;
    logic [63:0] up;
    logic [31:0] ma, mb, qm, rm;
    bit          sgn;
    cyc = 0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {exp_hi, exp_lo} = sp;
        cyc = 1;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {exp_hi, exp_lo} = up;
        cyc = 1;
      end
      OP_DIV, OP_DIVU: begin
        sgn = (op == OP_DIV);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (mb == 0) begin qm = 32'hFFFF_FFFF; rm = ma; end
        else         begin qm = ma / mb;       rm = ma % mb; end
        exp_lo = (sgn && (a[31] != b[31])) ? -qm : qm;
        exp_hi = (sgn && a[31]) ? -rm : rm;
        cyc = 32;
`ifdef MDU_DIV_EARLY_OUT_EN
        if (mb != 0 && mb > ma) cyc = 1;
`endif
      end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: cyc = 0;
    endcase
  endtask

  task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                        input logic [31:0] b, input bit pile_on);
    int cyc;
    int n;
    model(op, a, b, cyc);
    drive_op(op, a, b);
    if (pile_on) begin is_mult = 1; is_multu = 1; lo_wen = 1; end
    step;
    idle_inputs;
    if (cyc == 0) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd0);
      check({tag, " done"}, {31'd0, done}, 32'd0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin step; n++; end
      check({tag, " busy_cycles"}, 32'(n), 32'(cyc));
      check({tag, " done"}, {31'd0, done}, 32'd1);
    end
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    if (cyc != 0) begin
      step;
      check({tag, " done_drop"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int n;
    op_e op;
    logic [31:0] a, b;
    idle_inputs;
    reset = 1;
    step; step;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    exp_hi = 0; exp_lo = 0;
    reset = 0;
    step;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 0);
    run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 0);
    run_op("div_prio", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1);
    run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 0);

    // Flush ten cycles into a divide: no commit, HI/LO keep their old values.
    drive_op(OP_DIVU, 32'd100, 32'd7);
    step;
    idle_inputs;
    repeat (9) step;
    check("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1;
    step;
    flush = 0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush hi", hi, exp_hi);
    check("flush lo", lo, exp_lo);
    step;
    check("flush done_later", {31'd0, done}, 32'd0);

    drive_op(OP_MULT, 32'd3, 32'd4);
    flush = 1;
    step;
    idle_inputs;
    check("acc_flush busy", {31'd0, busy}, 32'd0);
    step;
    check("acc_flush done", {31'd0, done}, 32'd0);
    check("acc_flush lo", lo, exp_lo);

    // mthi held while a divide is in flight is only taken once busy drops.
    model(OP_DIVU, 32'd1000, 32'd3, n);
    drive_op(OP_DIVU, 32'd1000, 32'd3);
    step;
    drive_op(OP_MTHI, 32'h1234, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin step; n++; end
    check("mthi_busy hi_div", hi, exp_hi);
    check("mthi_busy lo_div", lo, exp_lo);
    step;
    idle_inputs;
    model(OP_MTHI, 32'h1234, 32'd0, n);
    check("mthi_retry hi", hi, 32'h1234);
    check("mthi_retry busy", {31'd0, busy}, 32'd0);
    check("mthi_retry done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      op = op_e'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      run_op($sformatf("rand%0d", i), op, a, b, 0);
    end

    // Reset in the middle of a divide returns everything to reset values at once.
    drive_op(OP_DIV, 32'hDEAD_BEEF, 32'd3);
    step;
    idle_inputs;
    repeat (5) step;
    reset = 1;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    step;
    reset = 0;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
